id_ex_stage_reg: RTL and testbench
==================================

// Module: id_ex_stage_reg
// PURPOSE
// - ID/EX pipeline register of the 5-stage CPU, directly downstream of the forwarding/hazard unit.
// - Consumes the unit's lock and Red_R1/Red_R2 selects; picks each operand from regfile, EX result or MEM result.
// - Registers operands plus control into EX; inserts a bubble on a load-use lock or a branch flush.
// PARAMETERS
// - DATA_W      32  operand, PC and immediate width
// - CTRL_W      16  opaque ALU/control bundle width, passed through unchanged
// - STALL_CNT_W 32  width of lock-bubble counter (used only with ID_EX_STALL_CNT_EN)
// PORTS
// - clk          in   1          pipeline clock, rising edge
// - rst          in   1          synchronous, active-high reset
// - hold         in   1          global freeze (memory wait); register keeps contents
// - flush        in   1          branch/jump taken in EX; squash the ID instruction
// - lock         in   1          load-use hazard from forwarding unit; insert bubble
// - Red_R1       in   2          R1 select: [0]=take EX_fwd, [1]=take MEM_fwd
// - Red_R2       in   2          R2 select, same encoding
// - ID_R1_data   in   DATA_W     regfile read port 1
// - ID_R2_data   in   DATA_W     regfile read port 2
// - EX_fwd       in   DATA_W     ALU result currently in EX
// - MEM_fwd      in   DATA_W     result currently in MEM (ALU or load data)
// - ID_pc        in   DATA_W     PC of ID instruction
// - ID_imm       in   DATA_W     extended immediate
// - ID_RW        in   5          destination register
// - ID_We        in   1          regfile write enable
// - ID_load      in   1          instruction is a load
// - ID_mem       in   2          memory op ([0]=store)
// - ID_ctrl      in   CTRL_W     control bundle
// - EX_A, EX_B   out  DATA_W     registered operands
// - EX_pc, EX_imm out DATA_W     registered PC / immediate
// - EX_RW        out  5          registered destination
// - EX_We, EX_load out 1        registered enables
// - EX_mem       out  2          registered memory op
// - EX_ctrl      out  CTRL_W     registered control bundle
// - EX_valid     out  1          1 = real instruction, 0 = bubble
// - stall_cnt    out  STALL_CNT_W lock-bubble count (only with ID_EX_STALL_CNT_EN)
// BEHAVIOUR
// - Clock: one clock, clk; reset rst is synchronous and active-high.
// - Reset: every output is 0, including EX_valid and stall_cnt.
// - Operand mux (combinational, same cycle): sel[0]=1 -> EX_fwd; else sel[1]=1 -> MEM_fwd; else regfile data.
// - Select 2'b11: EX_fwd wins (newest producer).
// - Update priority, evaluated each rising edge:
//   rst > hold > flush > lock > load.
// - hold: all outputs keep their values. Pending flush or lock is not recorded and must be re-presented.
// - flush or lock: bubble. EX_valid, EX_We, EX_load, EX_mem and EX_ctrl go to 0; data/PC/imm/RW go to 0.
//   - No state survives the bubble.
//   - ID is re-presented upstream on lock; the forwarding unit re-evaluates next cycle.
// - Load: every EX_* output takes its ID_* or muxed value and EX_valid=1.
// - Latency: 1 cycle from ID inputs to EX outputs.
// - No combinational path from any input to any output.
// - Width: ID_RW is always 5 bits; operands are never truncated or extended.
// CONFIGURATION
// - Macro ID_EX_STALL_CNT_EN.
// - Defined: stall_cnt increments by 1 on each edge with lock=1, hold=0, flush=0 and rst=0.
//   - Saturates at all-ones and never wraps; cleared only by rst.
// - Undefined: the stall_cnt port and counter logic are absent. All other behaviour is identical.
// TESTING
// - Reset: rst=1 for 2 cycles with random inputs -> all outputs 0, EX_valid=0.
// - Forwarding: ID_R1_data=1, EX_fwd=2, MEM_fwd=3.
//   - Red_R1=00 -> EX_A=1
//   - Red_R1=01 -> EX_A=2
//   - Red_R1=10 -> EX_A=3
//   - Red_R1=11 -> EX_A=2
//   - Same checks on Red_R2/EX_B.
// - Lock: ID_We=1, ID_load=1, lock=1 for 1 cycle -> next cycle EX_valid=0, EX_We=0, EX_load=0;
//   - lock=0 following cycle -> instruction loads with EX_valid=1.
// - Flush vs hold: hold=1 with flush=1 -> outputs unchanged.
//   - hold=0, flush=1, lock=1 -> bubble. With the macro defined, stall_cnt does not increment.
// - Counter (macro defined, STALL_CNT_W=4): 20 lock cycles -> stall_cnt=4'hF, held at 15.
//   - rst -> 0.

Source files
------------

// File: rtl/id_ex_stage_reg_if.sv
// ID/EX pipeline register bus: ID-side inputs, hazard controls and EX-side outputs.
// Optional stall counter signal present only when ID_EX_STALL_CNT_EN is defined.
interface id_ex_stage_reg_if #(
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned CTRL_W      = 16
`ifdef ID_EX_STALL_CNT_EN
  , parameter int unsigned STALL_CNT_W = 32
`endif
);
  logic              hold;
  logic              flush;
  logic              lock;
  logic [1:0]        Red_R1;
  logic [1:0]        Red_R2;
  logic [DATA_W-1:0] ID_R1_data;
  logic [DATA_W-1:0] ID_R2_data;
  logic [DATA_W-1:0] EX_fwd;
  logic [DATA_W-1:0] MEM_fwd;
  logic [DATA_W-1:0] ID_pc;
  logic [DATA_W-1:0] ID_imm;
  logic [4:0]        ID_RW;
  logic              ID_We;
  logic              ID_load;
  logic [1:0]        ID_mem;
  logic [CTRL_W-1:0] ID_ctrl;

  logic [DATA_W-1:0] EX_A;
  logic [DATA_W-1:0] EX_B;
  logic [DATA_W-1:0] EX_pc;
  logic [DATA_W-1:0] EX_imm;
  logic [4:0]        EX_RW;
  logic              EX_We;
  logic              EX_load;
  logic [1:0]        EX_mem;
  logic [CTRL_W-1:0] EX_ctrl;
  logic              EX_valid;
`ifdef ID_EX_STALL_CNT_EN
  logic [STALL_CNT_W-1:0] stall_cnt;
`endif

  // Upstream driver side (decode stage + forwarding unit)
  modport master (
    output hold, flush, lock, Red_R1, Red_R2, ID_R1_data, ID_R2_data, EX_fwd, MEM_fwd,
           ID_pc, ID_imm, ID_RW, ID_We, ID_load, ID_mem, ID_ctrl,
    input  EX_A, EX_B, EX_pc, EX_imm, EX_RW, EX_We, EX_load, EX_mem, EX_ctrl, EX_valid
`ifdef ID_EX_STALL_CNT_EN
    , input stall_cnt
`endif
  );

  // Pipeline register side
  modport slave (
    input  hold, flush, lock, Red_R1, Red_R2, ID_R1_data, ID_R2_data, EX_fwd, MEM_fwd,
           ID_pc, ID_imm, ID_RW, ID_We, ID_load, ID_mem, ID_ctrl,
    output EX_A, EX_B, EX_pc, EX_imm, EX_RW, EX_We, EX_load, EX_mem, EX_ctrl, EX_valid
`ifdef ID_EX_STALL_CNT_EN
    , output stall_cnt
`endif
  );
endinterface

// File: rtl/id_ex_stage_reg.sv
// ID/EX pipeline register with operand forwarding mux and bubble insertion.
// Update priority each edge: rst > hold > flush > lock > load.
// Optional feature macro: ID_EX_STALL_CNT_EN adds a saturating lock-bubble counter.
module id_ex_stage_reg #(
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned CTRL_W      = 16
`ifdef ID_EX_STALL_CNT_EN
  , parameter int unsigned STALL_CNT_W = 32
`endif
) (
  input logic             clk,
  input logic             rst,
  id_ex_stage_reg_if.slave bus
);

  logic [DATA_W-1:0] opnd_a;
  logic [DATA_W-1:0] opnd_b;

  // Operand select: EX result is newest, so it wins over MEM when both are flagged
  always_comb begin
    opnd_a = bus.ID_R1_data;
    opnd_b = bus.ID_R2_data;
    if (bus.Red_R1[0])      opnd_a = bus.EX_fwd;
    else if (bus.Red_R1[1]) opnd_a = bus.MEM_fwd;
    if (bus.Red_R2[0])      opnd_b = bus.EX_fwd;
    else if (bus.Red_R2[1]) opnd_b = bus.MEM_fwd;
  end

  // Pipeline register: freeze on hold, bubble on flush/lock, otherwise load
  always_ff @(posedge clk) begin
    if (rst || (!bus.hold && (bus.flush || bus.lock))) begin
      bus.EX_A     <= DATA_W'(0);
      bus.EX_B     <= DATA_W'(0);
      bus.EX_pc    <= DATA_W'(0);
      bus.EX_imm   <= DATA_W'(0);
      bus.EX_RW    <= 5'd0;
      bus.EX_We    <= 1'b0;
      bus.EX_load  <= 1'b0;
      bus.EX_mem   <= 2'd0;
      bus.EX_ctrl  <= CTRL_W'(0);
      bus.EX_valid <= 1'b0;
    end else if (!bus.hold) begin
      bus.EX_A     <= opnd_a;
      bus.EX_B     <= opnd_b;
      bus.EX_pc    <= bus.ID_pc;
      bus.EX_imm   <= bus.ID_imm;
      bus.EX_RW    <= bus.ID_RW;
      bus.EX_We    <= bus.ID_We;
      bus.EX_load  <= bus.ID_load;
      bus.EX_mem   <= bus.ID_mem;
      bus.EX_ctrl  <= bus.ID_ctrl;
      bus.EX_valid <= 1'b1;
    end
  end

`ifdef ID_EX_STALL_CNT_EN
  // Lock-bubble counter: counts only bubbles caused by lock alone, saturates at all-ones
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.stall_cnt <= STALL_CNT_W'(0);
    end else if (bus.lock && !bus.hold && !bus.flush && (bus.stall_cnt != {STALL_CNT_W{1'b1}})) begin
      bus.stall_cnt <= bus.stall_cnt + STALL_CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_id_ex_stage_reg.sv
// Self-checking bench for id_ex_stage_reg: scoreboard of expected EX registers,
// directed forwarding/lock/flush/hold steps, optional counter checks under ID_EX_STALL_CNT_EN.
module tb_id_ex_stage_reg;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned CTRL_W = 16;
  localparam int unsigned SCW    = 4;

  typedef struct packed {
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic [DATA_W-1:0] pc;
    logic [DATA_W-1:0] imm;
    logic [4:0]        rw;
    logic              we;
    logic              load;
    logic [1:0]        mem;
    logic [CTRL_W-1:0] ctrl;
    logic              valid;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;
  exp_t mdl;
  exp_t sb[$];
  logic [SCW-1:0] mcnt;

  always #5 clk = ~clk;

`ifdef ID_EX_STALL_CNT_EN
  id_ex_stage_reg_if #(.DATA_W(DATA_W), .CTRL_W(CTRL_W), .STALL_CNT_W(SCW)) bif();
  id_ex_stage_reg #(.DATA_W(DATA_W), .CTRL_W(CTRL_W), .STALL_CNT_W(SCW)) dut (
    .clk(clk), .rst(rst), .bus(bif));
`else
  id_ex_stage_reg_if #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) bif();
  id_ex_stage_reg #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) dut (
    .clk(clk), .rst(rst), .bus(bif));
`endif

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t observed();
    exp_t o;
    o.a = bif.EX_A;  o.b = bif.EX_B;  o.pc = bif.EX_pc;  o.imm = bif.EX_imm;
    o.rw = bif.EX_RW; o.we = bif.EX_We; o.load = bif.EX_load; o.mem = bif.EX_mem;
    o.ctrl = bif.EX_ctrl; o.valid = bif.EX_valid;
    return o;
  endfunction

  function automatic logic [DATA_W-1:0] pick(input logic [1:0] sel, input logic [DATA_W-1:0] rf);
    if (sel == 2'b01 || sel == 2'b11) return bif.EX_fwd;
    if (sel == 2'b10) return bif.MEM_fwd;
    return rf;
  endfunction

  // Reference model: next expected register contents from the inputs presented now
  task automatic model_step();
    if (rst) begin
      mdl = '0;
      mcnt = '0;
    end else if (!bif.hold) begin
      if (bif.flush || bif.lock) begin
        mdl = '0;
        if (!bif.flush && mcnt != 4'hF) mcnt = mcnt + 4'd1;
      end else begin
        mdl.a = pick(bif.Red_R1, bif.ID_R1_data);
        mdl.b = pick(bif.Red_R2, bif.ID_R2_data);
        mdl.pc = bif.ID_pc; mdl.imm = bif.ID_imm; mdl.rw = bif.ID_RW;
        mdl.we = bif.ID_We; mdl.load = bif.ID_load; mdl.mem = bif.ID_mem;
        mdl.ctrl = bif.ID_ctrl; mdl.valid = 1'b1;
      end
    end
  endtask

  task automatic cycle(input string tag);
    exp_t e;
    model_step();
    sb.push_back(mdl);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk(tag, 256'(observed()), 256'(e));
`ifdef ID_EX_STALL_CNT_EN
    chk({tag, "_cnt"}, 256'(bif.stall_cnt), 256'(mcnt));
`endif
  endtask

  task automatic rand_inputs();
    bif.Red_R1 = 2'($urandom); bif.Red_R2 = 2'($urandom);
    bif.ID_R1_data = $urandom; bif.ID_R2_data = $urandom;
    bif.EX_fwd = $urandom; bif.MEM_fwd = $urandom;
    bif.ID_pc = $urandom; bif.ID_imm = $urandom; bif.ID_RW = 5'($urandom);
    bif.ID_We = 1'($urandom); bif.ID_load = 1'($urandom); bif.ID_mem = 2'($urandom);
    bif.ID_ctrl = 16'($urandom);
  endtask

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin : stim
    logic [DATA_W-1:0] fwd_exp [4];
    exp_t snap;
    logic [SCW-1:0] cnt_snap;
    fwd_exp[0] = 32'd1; fwd_exp[1] = 32'd2; fwd_exp[2] = 32'd3; fwd_exp[3] = 32'd2;
    mdl = '0;
    mcnt = '0;

    // Reset with random inputs, including random hazard controls
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      rand_inputs();
      bif.hold = 1'($urandom); bif.flush = 1'($urandom); bif.lock = 1'($urandom);
      cycle("reset");
    end
    chk("reset_valid", 256'(bif.EX_valid), 256'(1'b0));
`ifdef ID_EX_STALL_CNT_EN
    chk("reset_cnt", 256'(bif.stall_cnt), 256'(0));
`endif
    rst = 1'b0;
    bif.hold = 1'b0; bif.flush = 1'b0; bif.lock = 1'b0;

    // Forwarding selects on both operands
    rand_inputs();
    bif.ID_R1_data = 32'd1; bif.ID_R2_data = 32'd1;
    bif.EX_fwd = 32'd2; bif.MEM_fwd = 32'd3;
    for (int s = 0; s < 4; s++) begin
      bif.Red_R1 = 2'(s); bif.Red_R2 = 2'(3 - s);
      cycle("fwd_load");
      chk("fwd_ex_a", 256'(bif.EX_A), 256'(fwd_exp[s]));
      chk("fwd_ex_b", 256'(bif.EX_B), 256'(fwd_exp[3 - s]));
      chk("fwd_valid", 256'(bif.EX_valid), 256'(1'b1));
    end

    // Load-use lock: one bubble, then the re-presented instruction loads
    bif.ID_We = 1'b1; bif.ID_load = 1'b1; bif.ID_mem = 2'b01; bif.ID_ctrl = 16'hBEEF;
    bif.lock = 1'b1;
    cycle("lock_bubble");
    chk("lock_valid", 256'(bif.EX_valid), 256'(1'b0));
    chk("lock_we", 256'(bif.EX_We), 256'(1'b0));
    chk("lock_load", 256'(bif.EX_load), 256'(1'b0));
    chk("lock_ctrl", 256'(bif.EX_ctrl), 256'(0));
    bif.lock = 1'b0;
    cycle("lock_release");
    chk("release_valid", 256'(bif.EX_valid), 256'(1'b1));
    chk("release_load", 256'(bif.EX_load), 256'(1'b1));
    chk("release_ctrl", 256'(bif.EX_ctrl), 256'(16'hBEEF));

    // Hold dominates flush: registers frozen even though ID changes
    snap = observed();
`ifdef ID_EX_STALL_CNT_EN
    cnt_snap = bif.stall_cnt;
`else
    cnt_snap = mcnt;
`endif
    bif.hold = 1'b1; bif.flush = 1'b1; bif.lock = 1'b1;
    bif.ID_pc = 32'h1234_5678;
    cycle("hold_flush");
    chk("hold_keep", 256'(observed()), 256'(snap));

    // Flush with lock: bubble, counter untouched
    bif.hold = 1'b0;
    cycle("flush_lock");
    chk("flush_valid", 256'(bif.EX_valid), 256'(1'b0));
    chk("flush_pc", 256'(bif.EX_pc), 256'(0));
`ifdef ID_EX_STALL_CNT_EN
    chk("flush_cnt", 256'(bif.stall_cnt), 256'(cnt_snap));
`endif
    bif.flush = 1'b0;

    // Long lock run: saturation of the bubble counter
    for (int i = 0; i < 20; i++) cycle("lock_run");
`ifdef ID_EX_STALL_CNT_EN
    chk("cnt_sat", 256'(bif.stall_cnt), 256'(4'hF));
    cycle("lock_sat_hold");
    chk("cnt_sat_hold", 256'(bif.stall_cnt), 256'(4'hF));
`endif
    bif.lock = 1'b0;
    rst = 1'b1;
    cycle("rst_again");
`ifdef ID_EX_STALL_CNT_EN
    chk("cnt_rst", 256'(bif.stall_cnt), 256'(0));
`endif
    rst = 1'b0;

    // Random mix of hazard controls against the model
    for (int i = 0; i < 40; i++) begin
      rand_inputs();
      bif.hold  = ($urandom_range(0, 4) == 0);
      bif.flush = ($urandom_range(0, 5) == 0);
      bif.lock  = ($urandom_range(0, 3) == 0);
      cycle("random");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
